fifo_rd_stream: RTL

- Read-side drain engine for the dual-clock FIFO, running entirely in that FIFO's read-clock domain.
- Issues read strobes against the FIFO's registered-output read port (data and valid one cycle after the strobe) and absorbs that latency in a small prefetch buffer.
- Unpacks each FIFO word into RATIO narrower beats on a valid/ready stream toward the PE array.

---
 rtl/fifo_rd_stream_if.sv | 25 ++
 rtl/fifo_rd_stream.sv | 94 +++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// FIFO read-port and beat-stream signals for fifo_rd_stream.
// The master modport is the drain engine; the slave modport is the FIFO plus downstream consumer.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  out_vld;
  logic                  out_rdy;
  logic [OUT_WIDTH-1:0]  out_dat;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_valid, fifo_dout, out_rdy,
    output fifo_rd_en, out_vld, out_dat, out_last
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_dout, out_rdy,
    input  fifo_rd_en, out_vld, out_dat, out_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-clock drain engine: strobes a registered-output FIFO, prefetches words into a
// small circular buffer and unpacks each word LSB-first into RATIO beats on a valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned BUF_DEPTH  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  fifo_rd_stream_if.master               bus,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_cnt,
  output logic                           err
);
  localparam int unsigned RATIO  = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W:0]    CNT_LIMIT = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);

  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_cnt;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_inflight;
  logic                  r_err;

  logic                  w_rd_en;
  logic [CNT_W:0]        w_pending;
  logic                  w_full;
  logic                  w_push;
  logic                  w_err_set;
  logic                  w_vld;
  logic                  w_xfer;
  logic                  w_beat_last;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;
  logic [OUT_WIDTH-1:0]  w_slice;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Issue depends only on registered occupancy and fifo_empty, so out_rdy never reaches the FIFO strobe.
  assign w_pending = {1'b0, r_cnt} + (CNT_W+1)'(r_inflight);
  assign w_rd_en   = rst_n & ~bus.fifo_empty & (w_pending < CNT_LIMIT);

  assign w_full    = (r_cnt == CNT_FULL);
  assign w_push    = bus.fifo_valid & r_inflight & ~w_full;
  // Unsolicited data, a missing response, or a push into a full buffer all flag a protocol error.
  assign w_err_set = (bus.fifo_valid ^ r_inflight) | (bus.fifo_valid & r_inflight & w_full);

  assign w_vld       = (r_cnt != '0);
  assign w_beat_last = (r_beat == BEAT_LAST);
  assign w_xfer      = w_vld & bus.out_rdy;
  assign w_pop       = w_xfer & w_beat_last;

  assign w_head  = r_buf[r_head];
  assign w_slice = w_head[r_beat*OUT_WIDTH +: OUT_WIDTH];

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_vld    = w_vld;
  assign bus.out_dat    = w_vld ? w_slice : '0;
  assign bus.out_last   = w_vld & w_beat_last;
  assign buf_cnt        = r_cnt;
  assign err            = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_err_set) r_err <= 1'b1;
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_xfer) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_buf[r_tail] <= bus.fifo_dout;
  end
endmodule
